// File: rtl/native_mem_pkg.sv
// rtl/native_mem_pkg.sv - shared constants, FSM state and status layout for native_mem_slave
//
// Purpose : address map constants, request FSM states, target decode enum and
//           the console status word layout shared by native_mem_slave.
// Ports   : none (package).
package native_mem_pkg;

  localparam logic [31:0] CON_ADDR  = 32'h1000_0000;
  localparam logic [31:0] TEST_ADDR = 32'h2000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    TGT_SRAM,
    TGT_CON,
    TGT_TEST,
    TGT_FAULT
  } target_t;

  // Console status word: fill level in bits [15:8], full flag in bit 0.
  function automatic logic [31:0] con_status(input logic [7:0] level, input logic full);
    return {16'd0, level, 7'd0, full};
  endfunction

endpackage

// File: rtl/native_mem_con_fifo.sv
// rtl/native_mem_con_fifo.sv - console byte FIFO with extra-bit wrap pointers
//
// Purpose : DEPTH-entry FIFO (DEPTH power of two, >= 2); pointers carry one
//           extra bit so full and empty are distinguishable.
// Ports   : clk, rst (async, active-high)
//           push, push_data  - write side
//           pop              - read side, ignored while empty
//           head             - current head entry
//           empty, full, level - occupancy
module native_mem_con_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = store[rptr[AW-1:0]];

endmodule

// File: rtl/native_mem_slave.sv
// rtl/native_mem_slave.sv - native-bus memory slave with SRAM, console and test-end ports
//
// Purpose : services native mem_valid/mem_ready requests against an SRAM,
//           a console byte FIFO (0x1000_0000) and a test-end register
//           (0x2000_0000); any other address is a sticky fault.
//           Console FIFO is built only when NATIVE_MEM_CONSOLE_EN is defined.
// Ports   : clk, reset (async, active-high)
//           mem_valid, mem_addr, mem_wdata, mem_wstrb -> mem_ready, mem_rdata
//           con_valid, con_data, con_ready  - console byte stream
//           tests_passed, err, err_addr     - sticky status
module native_mem_slave
  import native_mem_pkg::*;
#(
  parameter int          SIZE_WORDS  = 32768,
  parameter int          WAIT_STATES = 0,
  parameter int          CON_DEPTH   = 16,
  parameter logic [31:0] PASS_MAGIC  = 32'd123456789
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        tests_passed,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int          IW         = $clog2(SIZE_WORDS);
  localparam logic [31:0] SRAM_BYTES = 32'(SIZE_WORDS) << 2;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;

  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        cur_write;
  target_t     tgt;
  logic        stall;
  logic        going_ack;
  logic [31:0] read_word;
  logic [31:0] con_rd_word;
  logic [IW-1:0] idx;

  logic [31:0] sram [SIZE_WORDS];

  // In IDLE the live bus is used so a zero-wait request completes on the
  // edge that accepts it; afterwards the latched copy is used.
  assign cur_addr  = (state == ST_IDLE) ? mem_addr  : addr_q;
  assign cur_wdata = (state == ST_IDLE) ? mem_wdata : wdata_q;
  assign cur_wstrb = (state == ST_IDLE) ? mem_wstrb : wstrb_q;
  assign cur_write = |cur_wstrb;
  assign idx       = cur_addr[IW+1:2];

  always_comb begin
    if (cur_addr < SRAM_BYTES)      tgt = TGT_SRAM;
    else if (cur_addr == CON_ADDR)  tgt = TGT_CON;
    else if (cur_addr == TEST_ADDR) tgt = TGT_TEST;
    else                            tgt = TGT_FAULT;
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (WAIT_STATES == 0 && !stall) begin
            next_state = ST_ACK;
          end else begin
            next_state = ST_WAIT;
            next_cnt   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) next_cnt = cnt - 4'd1;
        // Leave on the edge where the counter reaches zero, unless stalled.
        if (cnt <= 4'd1 && !stall) next_state = ST_ACK;
      end
      ST_ACK:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Every side effect of a request happens on the edge entering ACK, so a
  // reset anywhere before that edge leaves no trace.
  assign going_ack = !reset && (next_state == ST_ACK) && (state != ST_ACK);

  always_comb begin
    case (tgt)
      TGT_SRAM: read_word = sram[idx];
      TGT_CON:  read_word = con_rd_word;
      TGT_TEST: read_word = {31'd0, tests_passed};
      default:  read_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      rdata_q      <= 32'd0;
      tests_passed <= 1'b0;
      err          <= 1'b0;
      err_addr     <= 32'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (state == ST_IDLE && mem_valid) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (going_ack) begin
        rdata_q <= read_word;
        if (tgt == TGT_TEST && cur_write && cur_wdata == PASS_MAGIC) tests_passed <= 1'b1;
        if (tgt == TGT_FAULT) begin
          err <= 1'b1;
          if (!err) err_addr <= cur_addr;
        end
      end
    end
  end

  // SRAM contents survive reset so a bench can preload them.
  always_ff @(posedge clk) begin
    if (going_ack && tgt == TGT_SRAM) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) sram[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  assign mem_ready = (state == ST_ACK);
  assign mem_rdata = rdata_q;

`ifdef NATIVE_MEM_CONSOLE_EN
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [7:0]                   fifo_head;
  logic [$clog2(CON_DEPTH):0]   fifo_level;
  logic                         con_push;

  assign con_push = going_ack && tgt == TGT_CON && cur_write;
  assign stall    = (tgt == TGT_CON) && cur_write && fifo_full;

  native_mem_con_fifo #(
    .DEPTH(CON_DEPTH),
    .WIDTH(8)
  ) u_con_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (con_push),
    .push_data(cur_wdata[7:0]),
    .pop      (con_valid && con_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level)
  );

  assign con_valid   = !fifo_empty;
  // Storage is not reset; mask the head so con_data reads 0 when empty.
  assign con_data    = fifo_empty ? 8'd0 : fifo_head;
  assign con_rd_word = con_status(8'(fifo_level), fifo_full);
`else
  logic [31:0] con_unused;
  assign con_unused  = {31'(CON_DEPTH), con_ready};
  assign stall       = 1'b0;
  assign con_valid   = 1'b0;
  assign con_data    = 8'd0;
  assign con_rd_word = 32'd0;
`endif

endmodule
